// File: rtl/luma_stream.sv
// RGB-to-grey streaming converter: one frame of NUM_PIXEL pixels per start request,
// two-stage pipeline with valid/ready handshakes on both sides and a binarised output.
module luma_stream #(
   parameter int DATA_W    = 10,
   parameter int NUM_PIXEL = 169,
   parameter int FRAC_W    = 10,
   parameter int W_R       = 306,
   parameter int W_G       = 601,
   parameter int W_B       = 117
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [DATA_W-1:0] i_threshold,
   output logic              o_read_request,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_red,
   input  logic [DATA_W-1:0] i_green,
   input  logic [DATA_W-1:0] i_blue,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_gray,
   output logic              o_bw,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam int CNT_W = $clog2(NUM_PIXEL + 1);
   localparam int SUM_W = 2 * DATA_W + FRAC_W + 2;

   localparam logic [SUM_W-1:0] WR_EXT   = SUM_W'(W_R);
   localparam logic [SUM_W-1:0] WG_EXT   = SUM_W'(W_G);
   localparam logic [SUM_W-1:0] WB_EXT   = SUM_W'(W_B);
   localparam logic [SUM_W-1:0] GRAY_MAX = {{(SUM_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXEL - 1);

   localparam logic [1:0] MODE_WEIGHTED = 2'b00;
   localparam logic [1:0] MODE_MAX      = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_inCount;
   logic [1:0]        r_mode;
   logic [DATA_W-1:0] r_threshold;

   logic              r_s1Valid;
   logic              r_s1Last;
   logic              r_s1Weighted;
   logic [DATA_W-1:0] r_s1Alt;
   logic [SUM_W-1:0]  r_prodR;
   logic [SUM_W-1:0]  r_prodG;
   logic [SUM_W-1:0]  r_prodB;

   logic              w_advance;
   logic              w_inFire;
   logic              w_outFire;
   logic [DATA_W-1:0] w_max;
   logic [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]  w_scaled;
   logic [DATA_W-1:0] w_satGray;
   logic [DATA_W-1:0] w_grayNext;

   // The whole pipeline moves together, so an output stall back-pressures the input.
   assign w_advance = !o_valid || i_ready;
   assign o_ready   = (r_state == ST_RUN) && w_advance;
   assign w_inFire  = i_valid && o_ready;
   assign w_outFire = o_valid && i_ready;
   assign o_done    = w_outFire && o_last && (r_state == ST_DRAIN);
   assign o_busy    = (r_state != ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_inCount      <= '0;
         r_mode         <= MODE_WEIGHTED;
         r_threshold    <= '0;
         o_read_request <= 1'b0;
      end else begin
         o_read_request <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state        <= ST_RUN;
                  r_mode         <= (i_mode == 2'b11) ? MODE_WEIGHTED : i_mode;
                  r_threshold    <= i_threshold;
                  r_inCount      <= '0;
                  o_read_request <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_inFire) begin
                  r_inCount <= r_inCount + 1'b1;
                  if (r_inCount == LAST_IDX) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (o_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_max = i_red;
      if (i_green > w_max) begin
         w_max = i_green;
      end
      if (i_blue > w_max) begin
         w_max = i_blue;
      end
   end

   // Stage 1: channel products for the weighted path, or the selected channel otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1Valid    <= 1'b0;
         r_s1Last     <= 1'b0;
         r_s1Weighted <= 1'b0;
         r_s1Alt      <= '0;
         r_prodR      <= '0;
         r_prodG      <= '0;
         r_prodB      <= '0;
      end else if (w_advance) begin
         r_s1Valid <= w_inFire;
         if (w_inFire) begin
            r_prodR      <= SUM_W'(i_red) * WR_EXT;
            r_prodG      <= SUM_W'(i_green) * WG_EXT;
            r_prodB      <= SUM_W'(i_blue) * WB_EXT;
            r_s1Last     <= (r_inCount == LAST_IDX);
            r_s1Weighted <= (r_mode == MODE_WEIGHTED);
            r_s1Alt      <= (r_mode == MODE_MAX) ? w_max : i_green;
         end
      end
   end

   assign w_sum      = r_prodR + r_prodG + r_prodB;
   assign w_scaled   = w_sum >> FRAC_W;
   assign w_satGray  = (w_scaled > GRAY_MAX) ? {DATA_W{1'b1}} : w_scaled[DATA_W-1:0];
   assign w_grayNext = r_s1Weighted ? w_satGray : r_s1Alt;

   // Stage 2: result registers double as the output port, held while the sink stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_gray  <= '0;
         o_bw    <= 1'b0;
         o_last  <= 1'b0;
      end else if (w_advance) begin
         o_valid <= r_s1Valid;
         o_last  <= r_s1Valid && r_s1Last;
         if (r_s1Valid) begin
            o_gray <= w_grayNext;
            o_bw   <= (w_grayNext > r_threshold);
         end
      end
   end

endmodule

// File: tb/tb_luma_stream.sv
// Self-checking bench for luma_stream: a queue-based reference model checked every cycle,
// plus directed frames whose outputs are pinned against hand-computed values.
module tb_luma_stream;

   localparam int DW = 10;
   localparam int NP = 4;
   localparam int FW = 10;
   localparam int WR = 306;
   localparam int WG = 601;
   localparam int WB = 117;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start;
   logic [1:0]    i_mode;
   logic [DW-1:0] i_threshold;
   logic          o_read_request;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] i_red;
   logic [DW-1:0] i_green;
   logic [DW-1:0] i_blue;
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_gray;
   logic          o_bw;
   logic          o_last;
   logic          o_busy;
   logic          o_done;

   luma_stream #(
      .DATA_W   (DW),
      .NUM_PIXEL(NP),
      .FRAC_W   (FW),
      .W_R      (WR),
      .W_G      (WG),
      .W_B      (WB)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_mode        (i_mode),
      .i_threshold   (i_threshold),
      .o_read_request(o_read_request),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_red         (i_red),
      .i_green       (i_green),
      .i_blue        (i_blue),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_gray        (o_gray),
      .o_bw          (o_bw),
      .o_last        (o_last),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int gray;
      bit bw;
      bit last;
      int acc;
      bit seen;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];
   exp_t newExp;
   int   mMode = 0;
   int   mThr = 0;
   int   mInCnt = 0;
   bit   mRun = 0;
   bit   mBusy = 0;
   bit   rrExp = 0;
   bit   latencyCheck = 0;
   int   cyc = 0;
   int   outIdx = 0;
   int   logGray[8];
   int   logBw[8];
   int   pixR[NP];
   int   pixG[NP];
   int   pixB[NP];
   int   readyMode = 0;
   int   stallReq = 0;
   int   stallServed = 0;
   int   stallLeft = 0;
   logic [31:0] rndReady;
   logic [31:0] rndDrv;
   logic expDone;
   logic expReady;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int modelGray(input int mode, input int r, input int g, input int b);
      int s;
      case (mode)
         1: begin
            s = r;
            if (g > s) s = g;
            if (b > s) s = b;
         end
         2: s = g;
         default: begin
            s = (r * WR + g * WG + b * WB) >> FW;
            if (s > (1 << DW) - 1) s = (1 << DW) - 1;
         end
      endcase
      return s;
   endfunction

   // Sink side: always ready, random, or a 5-cycle stall on request.
   always @(posedge i_clk) begin
      #1;
      if (stallReq != stallServed) begin
         stallServed = stallReq;
         stallLeft = 5;
      end
      if (stallLeft > 0) begin
         i_ready = 1'b0;
         stallLeft--;
      end else if (readyMode == 1) begin
         rndReady = $urandom;
         i_ready = (rndReady[1:0] != 2'b00);
      end else begin
         i_ready = 1'b1;
      end
   end

   // Compare process: checks every handshake-relevant output each cycle against the model.
   always @(negedge i_clk) begin
      cyc++;
      if (!i_rst_n) begin
         expQ.delete();
         mInCnt = 0;
         mRun = 0;
         mBusy = 0;
      end else begin
         expReady = mRun && (mInCnt < NP) && (!o_valid || i_ready);
         checkOutput("o_ready", o_ready, expReady);
         checkOutput("o_read_request", o_read_request, rrExp);
         checkOutput("o_busy", o_busy, mBusy);
         expDone = 1'b0;
         if (o_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("o_valid_unexpected", o_valid, 1'b0);
            end else begin
               if (latencyCheck && !expQ[0].seen) checkOutput("latency", cyc - expQ[0].acc, 2);
               expQ[0].seen = 1;
               checkOutput("o_gray", o_gray, expQ[0].gray);
               checkOutput("o_bw", o_bw, expQ[0].bw);
               checkOutput("o_last", o_last, expQ[0].last);
               expDone = i_ready && expQ[0].last;
            end
         end
         checkOutput("o_done", o_done, expDone);
         if (o_valid && i_ready && expQ.size() > 0) begin
            if (outIdx < 8) begin
               logGray[outIdx] = o_gray;
               logBw[outIdx] = o_bw;
            end
            outIdx++;
            void'(expQ.pop_front());
         end
         if (i_valid && o_ready) begin
            newExp.gray = modelGray(mMode, i_red, i_green, i_blue);
            newExp.bw = (newExp.gray > mThr);
            newExp.last = (mInCnt == NP - 1);
            newExp.acc = cyc;
            newExp.seen = 0;
            expQ.push_back(newExp);
            mInCnt++;
         end
         if (expDone) mBusy = 0;
      end
   end

   task automatic setPixel(input int k, input int r, input int g, input int b);
      pixR[k] = r;
      pixG[k] = g;
      pixB[k] = b;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_read_request"}, o_read_request, 0);
      checkOutput({tag, "_ready"}, o_ready, 0);
      checkOutput({tag, "_valid"}, o_valid, 0);
      checkOutput({tag, "_gray"}, o_gray, 0);
      checkOutput({tag, "_bw"}, o_bw, 0);
      checkOutput({tag, "_last"}, o_last, 0);
      checkOutput({tag, "_busy"}, o_busy, 0);
      checkOutput({tag, "_done"}, o_done, 0);
   endtask

   task automatic startFrame(input int mode, input int thr);
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_mode = 2'(mode);
      i_threshold = DW'(thr);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      mMode = (mode == 3) ? 0 : mode;
      mThr = thr;
      mInCnt = 0;
      mRun = 1;
      mBusy = 1;
      rrExp = 1;
      outIdx = 0;
      rndDrv = $urandom;
      i_mode = rndDrv[1:0];
      i_threshold = rndDrv[DW+1:2];
      @(posedge i_clk);
      #1;
      rrExp = 0;
   endtask

   task automatic sendPixels(input int first, input int last, input bit randValid, input bit pokeStart);
      int   k;
      int   guard;
      logic fire;
      bit   poked;
      k = first;
      guard = 0;
      poked = 0;
      while (k < last && guard < 1000) begin
         i_red = pixR[k][DW-1:0];
         i_green = pixG[k][DW-1:0];
         i_blue = pixB[k][DW-1:0];
         rndDrv = $urandom;
         i_valid = randValid ? rndDrv[0] : 1'b1;
         if (pokeStart && k == 1 && !poked) begin
            i_start = 1'b1;
            i_threshold = ~DW'(mThr);
            i_mode = 2'b10;
            poked = 1;
         end
         @(negedge i_clk);
         fire = i_valid && o_ready;
         @(posedge i_clk);
         #1;
         i_start = 1'b0;
         if (fire) k++;
         guard++;
      end
      i_valid = 1'b0;
      if (guard >= 1000) checkOutput("input_timeout", k, last);
   endtask

   task automatic waitDone(input bit pokeDone);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 200) begin
         @(negedge i_clk);
         n++;
         if (o_done) begin
            seen = 1;
            if (pokeDone) i_start = 1'b1;
         end
      end
      checkOutput("frame_done", seen, 1);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      checkOutput("outputs_in_frame", outIdx, NP);
      @(negedge i_clk);
      checkOutput("idle_after_done", o_busy, 0);
   endtask

   task automatic applyStimulus(input int mode, input int thr, input bit randValid,
                                input bit pokeStart, input bit pokeDone);
      startFrame(mode, thr);
      sendPixels(0, NP, randValid, pokeStart);
      waitDone(pokeDone);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_mode = 2'b00;
      i_threshold = '0;
      i_valid = 1'b0;
      i_red = '0;
      i_green = '0;
      i_blue = '0;

      repeat (3) @(posedge i_clk);
      #1;
      checkAllZero("reset");
      @(posedge i_clk);
      #3;
      i_rst_n = 1'b1;

      // Weighted mode, threshold 300.
      setPixel(0, 1023, 1023, 1023);
      setPixel(1, 1023, 0, 0);
      setPixel(2, 100, 100, 100);
      setPixel(3, 0, 0, 0);
      applyStimulus(0, 300, 0, 0, 0);
      checkOutput("wt_white_gray", logGray[0], 1023);
      checkOutput("wt_white_bw", logBw[0], 1);
      checkOutput("wt_red_gray", logGray[1], 305);
      checkOutput("wt_red_bw_thr300", logBw[1], 1);
      checkOutput("wt_grey100_gray", logGray[2], 100);
      checkOutput("wt_black_gray", logGray[3], 0);

      // Weighted mode, threshold equal to the red result.
      setPixel(0, 1023, 0, 0);
      setPixel(1, 0, 1023, 0);
      setPixel(2, 5, 900, 12);
      setPixel(3, 1, 2, 3);
      applyStimulus(0, 305, 1, 0, 0);
      checkOutput("wt_red_bw_thr305", logBw[0], 0);
      checkOutput("wt_green_gray", logGray[1], 600);
      checkOutput("wt_mixed_gray", logGray[2], 531);

      // Max mode and green pass-through with the same pixel.
      setPixel(0, 5, 900, 12);
      setPixel(1, 900, 5, 12);
      setPixel(2, 12, 5, 900);
      setPixel(3, 0, 0, 0);
      applyStimulus(1, 899, 0, 0, 0);
      checkOutput("max_g_gray", logGray[0], 900);
      checkOutput("max_g_bw", logBw[0], 1);
      checkOutput("max_r_gray", logGray[1], 900);
      checkOutput("max_b_gray", logGray[2], 900);
      applyStimulus(2, 900, 0, 0, 0);
      checkOutput("green_gray", logGray[0], 900);
      checkOutput("green_bw_equal_thr", logBw[0], 0);
      checkOutput("green_r_pix_gray", logGray[1], 5);

      // Mode 11 behaves as weighted.
      setPixel(0, 100, 100, 100);
      applyStimulus(3, 99, 0, 0, 0);
      checkOutput("mode3_gray", logGray[0], 100);
      checkOutput("mode3_bw", logBw[0], 1);

      // Continuous stream: latency, o_last/o_done, i_start on the done cycle ignored.
      for (int k = 0; k < NP; k++) setPixel(k, $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
      latencyCheck = 1;
      readyMode = 0;
      applyStimulus(0, 512, 0, 0, 1);
      latencyCheck = 0;

      // Sink stall of 5 cycles mid-frame.
      for (int k = 0; k < NP; k++) setPixel(k, $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
      startFrame(1, 400);
      sendPixels(0, 2, 0, 0);
      stallReq++;
      sendPixels(2, NP, 0, 0);
      waitDone(0);

      // i_start during RUN must not restart or relatch.
      for (int k = 0; k < NP; k++) setPixel(k, $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
      applyStimulus(0, 500, 0, 1, 0);

      // Reset mid-frame after two pixels, then a clean frame.
      setPixel(0, 1023, 1023, 1023);
      setPixel(1, 700, 700, 700);
      startFrame(0, 10);
      sendPixels(0, 2, 0, 0);
      @(posedge i_clk);
      #3;
      checkOutput("pre_reset_valid", o_valid, 1);
      i_rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      @(posedge i_clk);
      #3;
      i_rst_n = 1'b1;
      for (int k = 0; k < NP; k++) setPixel(k, 200 + k, 300 + k, 400 + k);
      applyStimulus(2, 301, 0, 0, 0);
      checkOutput("post_reset_gray0", logGray[0], 300);
      checkOutput("post_reset_bw1", logBw[1], 0);
      checkOutput("post_reset_bw2", logBw[2], 1);

      // Randomised frames with random valid/ready.
      readyMode = 1;
      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < NP; k++) setPixel(k, $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
         applyStimulus($urandom_range(3), $urandom_range(1023), 1, ($urandom_range(3) == 0), 0);
      end
      readyMode = 0;
      repeat (3) @(posedge i_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
